// File: rtl/pc_counter_unit.sv
// Hack-style PC/status storage: 1-bit load register, 16-bit clear/load/increment
// counter, and an exposed combinational +1 incrementer.
//
// Ports:
//   clock, reset      - rising-edge clock, async active-high clear of all state
//   bit_in, bit_load  - bit register data / write enable -> bit_out
//   in, clear, load,
//   increment         - counter load value and controls (clear > load > inc)
//   out               - counter contents
//   inc_a -> inc_sum  - combinational inc_a + 1, wrapping

module pc_counter_inc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] sum_o
);

  // Ripple half-adder chain with an implicit carry-in of 1.
  // The final carry-out is dropped, so only WIDTH-1 carries exist.
  logic [WIDTH-2:0] carry;

  assign sum_o[0] = ~a_i[0];
  assign carry[0] = a_i[0];

  for (genvar i = 1; i < WIDTH; i++) begin : g_ha
    assign sum_o[i] = a_i[i] ^ carry[i-1];
    if (i < WIDTH - 1) begin : g_c
      assign carry[i] = a_i[i] & carry[i-1];
    end
  end

endmodule

module pc_counter_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_load,
  output logic             bit_out,
  input  logic [WIDTH-1:0] in,
  input  logic             clear,
  input  logic             load,
  input  logic             increment,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] inc_a,
  output logic [WIDTH-1:0] inc_sum
);

  logic             bit_q;
  logic             bit_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] inc_mux;
  logic [WIDTH-1:0] load_mux;

  pc_counter_inc #(.WIDTH(WIDTH)) u_inc_ext (
    .a_i   (inc_a),
    .sum_o (inc_sum)
  );

  pc_counter_inc #(.WIDTH(WIDTH)) u_inc_cnt (
    .a_i   (cnt_q),
    .sum_o (cnt_inc)
  );

  // Clear is the outermost mux so it wins over load and increment;
  // unselected inputs never reach the register.
  assign inc_mux  = increment ? cnt_inc : cnt_q;
  assign load_mux = load ? in : inc_mux;
  assign cnt_d    = clear ? '0 : load_mux;

  assign bit_d = bit_load ? bit_in : bit_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      bit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bit_q <= bit_d;
    end
  end

  assign out     = cnt_q;
  assign bit_out = bit_q;

endmodule

// File: tb/tb_pc_counter_unit.sv
// Self-checking bench for pc_counter_unit.
// Expected values come from a behavioural model pushed through a scoreboard queue.

module tb_pc_counter_unit;

  logic        clock;
  logic        reset;
  logic        bit_in;
  logic        bit_load;
  logic        bit_out;
  logic [15:0] din;
  logic        clear;
  logic        load;
  logic        increment;
  logic [15:0] dout;
  logic [15:0] inc_a;
  logic [15:0] inc_sum;

  typedef struct packed {
    logic [15:0] o;
    logic        b;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] m_out;
  logic        m_bit;
  int          checks;
  int          failures;

  pc_counter_unit dut (
    .clock     (clock),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_load  (bit_load),
    .bit_out   (bit_out),
    .in        (din),
    .clear     (clear),
    .load      (load),
    .increment (increment),
    .out       (dout),
    .inc_a     (inc_a),
    .inc_sum   (inc_sum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive, push model result, compare after rise.
  task automatic cyc(
    input string       tag,
    input logic        clr,
    input logic        ld,
    input logic        inc,
    input logic [15:0] d,
    input logic        bl,
    input logic        bi
  );
    exp_t e;
    clear     = clr;
    load      = ld;
    increment = inc;
    din       = d;
    bit_load  = bl;
    bit_in    = bi;
    if (clr)
      m_out = 16'h0000;
    else if (ld)
      m_out = d;
    else if (inc)
      m_out = m_out + 16'd1;
    if (bl)
      m_bit = bi;
    e.o = m_out;
    e.b = m_bit;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    check({tag, "_out"}, dout, e.o);
    check({tag, "_bit"}, {15'd0, bit_out}, {15'd0, e.b});
    @(negedge clock);
  endtask

  task automatic inc_chk(input logic [15:0] a);
    logic [16:0] s;
    s     = {1'b0, a} + 17'd1;
    inc_a = a;
    #1;
    check("inc_sum", inc_sum, s[15:0]);
  endtask

  initial begin
    logic [15:0] r;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bit_in    = 1'b0;
    bit_load  = 1'b0;
    din       = 16'h0000;
    clear     = 1'b0;
    load      = 1'b0;
    increment = 1'b0;
    inc_a     = 16'h0000;
    m_out     = 16'h0000;
    m_bit     = 1'b0;

    @(negedge clock);
    check("rst_out", dout, 16'h0000);
    check("rst_bit", {15'd0, bit_out}, 16'h0000);
    reset = 1'b0;
    @(negedge clock);

    // Bit register
    cyc("b_idle",  0, 0, 0, 16'h0, 0, 0);
    cyc("b_ld1",   0, 0, 0, 16'h0, 1, 1);
    cyc("b_hold1", 0, 0, 0, 16'h0, 0, 0);
    cyc("b_hold2", 0, 0, 0, 16'h0, 0, 0);
    cyc("b_ld0",   0, 0, 0, 16'h0, 1, 0);
    cyc("b_hold0", 0, 0, 0, 16'h0, 0, 1);

    // Counter sequence and priority with random load values
    for (int i = 0; i < 100; i++) begin
      r = 16'($urandom_range(0, 16'hFFFF));
      cyc("c_clr",   1, 0, 0, r, 0, 0);
      cyc("c_inc1",  0, 0, 1, r, 0, 0);
      cyc("c_inc2",  0, 0, 1, r, 0, 0);
      cyc("c_load",  0, 1, 0, r, 0, 0);
      cyc("c_hold",  0, 0, 0, r, 0, 0);
      cyc("c_inc",   0, 0, 1, r, 0, 0);
      cyc("c_clr2",  1, 0, 0, r, 0, 0);
      cyc("p_li",    0, 1, 1, r, 0, 0);
      cyc("p_ci",    1, 0, 1, r, 0, 0);
      cyc("p_li2",   0, 1, 1, r, 0, 0);
      cyc("p_cl",    1, 1, 0, r, 0, 0);
      cyc("p_li3",   0, 1, 1, r, 0, 0);
      cyc("p_cli",   1, 1, 1, r, 0, 0);
    end

    // Wrap and unselected-input isolation
    cyc("w_load",  0, 1, 0, 16'hFFFF, 0, 0);
    cyc("w_inc",   0, 0, 1, 16'hFFFF, 0, 0);
    cyc("x_inc",   0, 0, 1, 16'hxxxx, 0, 0);
    inc_chk(16'hFFFF);
    inc_chk(16'h00FF);
    inc_chk(16'h1234);
    inc_chk(16'h0000);

    // Async reset
    cyc("r_load",  0, 1, 0, 16'h5A5A, 1, 1);
    #2;
    reset = 1'b1;
    #1;
    check("r_async_out", dout, 16'h0000);
    check("r_async_bit", {15'd0, bit_out}, 16'h0000);
    m_out    = 16'h0000;
    m_bit    = 1'b0;
    load     = 1'b1;
    din      = 16'h1234;
    bit_load = 1'b1;
    bit_in   = 1'b1;
    @(posedge clock);
    #1;
    check("r_held_out", dout, 16'h0000);
    check("r_held_bit", {15'd0, bit_out}, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    cyc("r_rel",   0, 1, 0, 16'h0007, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
